// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - memory byte-select codes (match funct3[1:0])
//   - FSM state encoding
//   - access size and funct3 legality helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] BSEL_BYTE = 2'b00;
    localparam logic [1:0] BSEL_HALF = 2'b01;
    localparam logic [1:0] BSEL_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Access size in bytes from the width field (funct3[1:0]).
    function automatic logic [2:0] size_from_f3(input logic [1:0] sel);
        case (sel)
            BSEL_BYTE: size_from_f3 = 3'd1;
            BSEL_HALF: size_from_f3 = 3'd2;
            default:   size_from_f3 = 3'd4;
        endcase
    endfunction

    // Stores only exist in signed-width form; loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extension.
//   funct3 : load funct3 (LB/LH/LW/LBU/LHU)
//   raw    : 32-bit word read from memory, access starts at bit 0
//   ext    : sign- or zero-extended result
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        sext8 = 32'(v);
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        sext16 = 32'(v);
    endfunction

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = sext8(raw[7:0]);
            F3_H:    ext = sext16(raw[15:0]);
            F3_BU:   ext = {24'b0, raw[7:0]};
            F3_HU:   ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between the MEM stage
// and a byte-addressed data memory.
//   clk, rst             : clock, synchronous active-low reset
//   req_*                : request channel (valid/ready), funct3/addr/data/rd
//   mem_*                : data memory port, active for exactly one cycle
//   resp_*               : registered response channel (valid/ready)
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise they proceed as normal byte-addressed accesses.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_SPACE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [1:0]  mem_byte_sel,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_is_load,
    output logic        resp_fault
);

    state_t      state_q, state_d;
    logic        we_p1;
    logic [2:0]  f3_p1;
    logic [31:0] addr_p1;
    logic [31:0] wdata_p1;
    logic [31:0] ext_data;
    logic        req_fire;
    logic        req_fault;
    logic        misalign;
    logic [32:0] end_addr;

    lsu_load_ext u_ext (
        .funct3 (f3_p1),
        .raw    (mem_rdata),
        .ext    (ext_data)
    );

    // 33-bit end address so a wrapping address can never pass the range check.
    always_comb begin
        end_addr = {1'b0, req_addr} + {30'b0, size_from_f3(req_funct3[1:0])};
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == BSEL_HALF) && req_addr[0]) ||
                   ((req_funct3[1:0] == BSEL_WORD) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_fault = !f3_legal(req_we, req_funct3) ||
                    (end_addr > 33'(DMEM_SPACE)) || misalign;
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Memory port is gated by rst so a store sampled together with reset is dropped.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_byte_sel = '0;
        resp_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst;
                if (req_valid && rst) state_d = req_fault ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr     = rst ? addr_p1 : '0;
                mem_byte_sel = rst ? f3_p1[1:0] : '0;
                mem_wdata    = (rst && we_p1) ? wdata_p1 : '0;
                mem_wen      = rst && we_p1;
                mem_ren      = rst && !we_p1;
                state_d      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_fire = req_valid && req_ready;

    // ---- request capture (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_p1    <= req_we;
            f3_p1    <= req_funct3;
            addr_p1  <= req_addr;
            wdata_p1 <= req_wdata;
        end
    end

    // ---- response registers, held stable while in RESP ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_rdata   <= '0;
            resp_rd      <= '0;
            resp_is_load <= 1'b0;
            resp_fault   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        resp_rdata   <= '0;
                        resp_rd      <= req_rd;
                        resp_is_load <= !req_we;
                        resp_fault   <= req_fault;
                    end
                end
                ACCESS: begin
                    if (!we_p1) resp_rdata <= ext_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import lsu_pkg::*;

    localparam int DMEM = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_byte_sel;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_is_load;
    logic        resp_fault;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] dmem    [DMEM];
    logic [7:0] ref_mem [DMEM];

    mem_access_unit #(.DMEM_SPACE(DMEM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_byte_sel (mem_byte_sel),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_is_load (resp_is_load),
        .resp_fault   (resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end

    // Byte-addressed data memory: combinational read, write at posedge.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            logic [32:0] a;
            a = {1'b0, mem_addr} + 33'(i);
            if (a < 33'(DMEM)) mem_rdata[8*i +: 8] = dmem[int'(a)];
        end
    end

    always @(posedge clk) begin
        if (mem_wen) begin
            for (int i = 0; i < 4; i++) begin
                logic [32:0] a;
                int nb;
                a  = {1'b0, mem_addr} + 33'(i);
                nb = (mem_byte_sel == 2'b00) ? 1 : (mem_byte_sel == 2'b01) ? 2 : 4;
                if (i < nb && a < 33'(DMEM)) dmem[int'(a)] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: applies the access rules directly to a byte array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic fault, output logic [31:0] rdata);
        int size;
        longint end_a;
        logic legal;
        logic mis;
        logic [31:0] w;
        int v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end_a = longint'(addr) + longint'(size);
        mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (longint'(addr) % size) != 0;
`endif
        fault = !legal || (end_a > DMEM) || mis;
        rdata = '0;
        if (fault) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            w = '0;
            for (int i = 0; i < size; i++) w[8*i +: 8] = ref_mem[int'(addr) + i];
            case (f3)
                3'd0: begin v = int'(w[7:0]);  if (v >= 128)   v -= 256;   rdata = v; end
                3'd1: begin v = int'(w[15:0]); if (v >= 32768) v -= 65536; rdata = v; end
                default: rdata = w;
            endcase
        end
    endtask

    // One complete transaction; stall cycles hold resp_ready low while a
    // competing store request is presented that must not be taken.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input logic exp_fault, input logic [31:0] exp_rdata,
                           input int stall, input string tag);
        int n;
        int lat;
        int ren_n;
        int wen_n;
        logic [31:0] s_rdata;
        logic [4:0]  s_rd;
        logic        s_fault;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = 1;
        ren_n = 0;
        wen_n = 0;
        while (!resp_valid && lat < 6) begin
            if (mem_ren && mem_wen) chk({tag, "/ren_wen_both"}, 32'd1, 32'd0);
            if (mem_ren || mem_wen) begin
                chk({tag, "/mem_addr"}, mem_addr, addr);
                chk({tag, "/mem_byte_sel"}, 32'(mem_byte_sel), 32'(f3[1:0]));
                chk({tag, "/mem_wdata"}, mem_wdata, we ? wdata : 32'd0);
            end
            if (mem_ren) ren_n++;
            if (mem_wen) wen_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), exp_fault ? 32'd1 : 32'd2);
        chk({tag, "/ren_pulses"}, 32'(ren_n), (!exp_fault && !we) ? 32'd1 : 32'd0);
        chk({tag, "/wen_pulses"}, 32'(wen_n), (!exp_fault && we) ? 32'd1 : 32'd0);
        chk({tag, "/resp_fault"}, 32'(resp_fault), 32'(exp_fault));
        chk({tag, "/resp_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "/resp_rd"}, 32'(resp_rd), 32'(rd));
        chk({tag, "/resp_is_load"}, 32'(resp_is_load), 32'(!we));
        s_rdata = resp_rdata;
        s_rd    = resp_rd;
        s_fault = resp_fault;
        for (int s = 0; s < stall; s++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = F3_W;
            req_addr   = 32'h40;
            req_wdata  = 32'hBAD0BAD0;
            @(posedge clk);
            #1;
            chk({tag, "/stall_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "/stall_rdata"}, resp_rdata, s_rdata);
            chk({tag, "/stall_rd"}, 32'(resp_rd), 32'(s_rd));
            chk({tag, "/stall_fault"}, 32'(resp_fault), 32'(s_fault));
            chk({tag, "/stall_req_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "/stall_wen"}, 32'(mem_wen), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "/valid_drop"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        fault;
        logic [31:0] rdata;
        int          stall;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input logic fault, input logic [31:0] rdata, input int stall);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.fault = fault; v.rdata = rdata; v.stall = stall;
        vq.push_back(v);
    endtask

    initial begin
        logic        mf;
        logic [31:0] mr;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        logic [31:0] rwdata;

        for (int i = 0; i < DMEM; i++) begin
            dmem[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset/req_ready", 32'(req_ready), 32'd0);
        chk("reset/mem_en", 32'({mem_ren, mem_wen}), 32'd0);
        chk("reset/mem_addr", mem_addr, 32'd0);
        chk("reset/mem_wdata", mem_wdata, 32'd0);
        chk("reset/mem_byte_sel", 32'(mem_byte_sel), 32'd0);
        chk("reset/resp_valid", 32'(resp_valid), 32'd0);
        chk("reset/resp_rdata", resp_rdata, 32'd0);
        chk("reset/resp_misc", 32'({resp_rd, resp_is_load, resp_fault}), 32'd0);
        rst = 1'b1;
        #1;
        chk("reset/req_ready_release", 32'(req_ready), 32'd1);

        add(1, F3_W,  32'h10,  32'hDEADBEEF, 5'd1,  0, 32'h0,        0);
        add(0, F3_W,  32'h10,  32'h0,        5'd2,  0, 32'hDEADBEEF, 5);
        add(1, F3_W,  32'h20,  32'h1234A5C3, 5'd3,  0, 32'h0,        0);
        add(1, F3_B,  32'h20,  32'h00000080, 5'd4,  0, 32'h0,        0);
        add(0, F3_B,  32'h20,  32'h0,        5'd5,  0, 32'hFFFFFF80, 0);
        add(0, F3_BU, 32'h20,  32'h0,        5'd6,  0, 32'h00000080, 1);
        add(0, F3_H,  32'h20,  32'h0,        5'd7,  0, 32'hFFFFA580, 0);
        add(0, F3_HU, 32'h20,  32'h0,        5'd8,  0, 32'h0000A580, 0);
        add(0, F3_H,  32'h22,  32'h0,        5'd9,  0, 32'h00001234, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(0, F3_H,  32'h21,  32'h0,        5'd10, 1, 32'h0,        0);
`else
        add(0, F3_H,  32'h21,  32'h0,        5'd10, 0, 32'h000034A5, 0);
`endif
        add(1, F3_W,  32'h3FC, 32'hCAFEF00D, 5'd11, 0, 32'h0,        0);
        add(0, F3_W,  32'h3FC, 32'h0,        5'd12, 0, 32'hCAFEF00D, 0);
        add(0, F3_W,  32'h3FD, 32'h0,        5'd13, 1, 32'h0,        2);
        add(0, 3'b011, 32'h10, 32'h0,        5'd14, 1, 32'h0,        0);
        add(1, 3'b100, 32'h10, 32'h55555555, 5'd15, 1, 32'h0,        0);
        add(0, 3'b110, 32'h10, 32'h0,        5'd16, 1, 32'h0,        0);
        add(0, F3_W,  32'hFFFFFFFC, 32'h0,   5'd17, 1, 32'h0,        0);
        add(0, F3_B,  32'h3FF, 32'h0,        5'd18, 0, 32'hFFFFFFCA, 0);
        add(1, F3_H,  32'h3FE, 32'h00007F01, 5'd19, 0, 32'h0,        0);
        add(0, F3_HU, 32'h3FE, 32'h0,        5'd20, 0, 32'h00007F01, 0);
        add(0, F3_W,  32'h3FC, 32'h0,        5'd21, 0, 32'h7F01F00D, 0);
        add(0, F3_H,  32'h3FF, 32'h0,        5'd22, 1, 32'h0,        0);
        add(0, F3_W,  32'h10,  32'h0,        5'd23, 0, 32'hDEADBEEF, 0);

        foreach (vq[i]) begin
            model(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata, mf, mr);
            run_txn(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata, vq[i].rd,
                    vq[i].fault, vq[i].rdata, vq[i].stall, $sformatf("vec%0d", i));
        end

        // Reset during the access cycle of a store: the store must not land.
        model(1'b1, F3_W, 32'h30, 32'h11112222, mf, mr);
        run_txn(1'b1, F3_W, 32'h30, 32'h11112222, 5'd1, mf, mr, 0, "rst_acc_pre");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h30; req_wdata = 32'h99999999; req_rd = 5'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst_acc/wen_before", 32'(mem_wen), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_acc/req_ready", 32'(req_ready), 32'd0);
        chk("rst_acc/mem_en", 32'({mem_ren, mem_wen}), 32'd0);
        chk("rst_acc/mem_addr", mem_addr, 32'd0);
        chk("rst_acc/mem_wdata", mem_wdata, 32'd0);
        chk("rst_acc/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_acc/resp_misc", 32'({resp_rd, resp_is_load, resp_fault}), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_acc/req_ready_after", 32'(req_ready), 32'd1);
        run_txn(1'b0, F3_W, 32'h30, 32'h0, 5'd4, 1'b0, 32'h11112222, 0, "rst_acc_read");

        // Reset while a load response is waiting discards it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W;
        req_addr = 32'h10; req_rd = 5'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_resp/valid_before", 32'(resp_valid), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_resp/valid", 32'(resp_valid), 32'd0);
        chk("rst_resp/rdata", resp_rdata, 32'd0);
        chk("rst_resp/rd", 32'(resp_rd), 32'd0);
        rst = 1'b1;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            rwe = 1'($urandom % 2);
            rf3 = 3'($urandom % 8);
            if (($urandom % 4) != 0) begin
                if (rwe) rf3 = 3'($urandom % 3);
                else begin
                    case ($urandom % 5)
                        0: rf3 = F3_B;
                        1: rf3 = F3_H;
                        2: rf3 = F3_W;
                        3: rf3 = F3_BU;
                        default: rf3 = F3_HU;
                    endcase
                end
            end
            case ($urandom % 8)
                0: raddr = 32'(DMEM - 8) + 32'($urandom % 8);
                1: raddr = $urandom;
                default: raddr = 32'($urandom_range(0, 127));
            endcase
            rwdata = $urandom;
            model(rwe, rf3, raddr, rwdata, mf, mr);
            run_txn(rwe, rf3, raddr, rwdata, 5'($urandom % 32), mf, mr,
                    int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
